hazard_forward_unit: RTL
========================

# hazard_forward_unit

Parametrised forwarding and hazard unit for the scalar/vector AES pipeline (IF-ID-EX-MEM-WB). It produces per-operand forwarding selects for the EX stage, with scalar and vector register files kept as distinct namespaces and scalar register 0 never forwarded. It also holds a per-register scoreboard of pending multi-cycle writes from the vector/AES unit and raises a decode-stage stall on RAW, WAW and structural hazards. A saturating stall-cycle counter is provided for performance measurement.

## Interface

Parameters:
- NUM_SRC, 3: source operands per instruction.
- REG_AW, 5: register address width; NUM_REGS = 2**REG_AW per file.
- MAX_LAT, 8: largest multi-cycle latency; LAT_W = $clog2(MAX_LAT+1).
- ZERO_REG, 1: when 1, scalar register 0 never matches.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- EX_rs  in  NUM_SRC*REG_AW  EX-stage source addresses, packed, source i at [i*REG_AW +: REG_AW].
- EX_rs_vec  in  NUM_SRC  source file per operand: 1 = vector, 0 = scalar.
- EX_rs_en  in  NUM_SRC  source operand used.
- MEM_rd, WB_rd  in  REG_AW each  destination addresses.
- MEM_rd_vec, WB_rd_vec  in  1 each  destination file.
- MEM_wr, WB_wr  in  1 each  register write enable (either file).
- MEM_MemToReg  in  1  MEM instruction is a load.
- ID_valid  in  1  valid instruction in decode.
- ID_rs, ID_rs_vec, ID_rs_en  in  same shapes as the EX_ signals  decode sources.
- ID_rd  in  REG_AW  decode destination.
- ID_rd_vec  in  1  decode destination file.
- ID_wr  in  1  decode destination write enable.
- ID_lat  in  LAT_W  0 = single-cycle producer; >0 = multi-cycle unit latency.
- FwSel  out  NUM_SRC*2  per-operand forward select.
- ID_stall  out  1  hold IF/ID, inject bubble into EX.
- stall_cnt  out  32  saturating count of stalled cycles.

## Operation

- FwSel per source i, priority order:
  - 2'b01: MEM_wr, same file, address equal and MEM_MemToReg.
  - 2'b10: MEM_wr, same file, address equal.
  - 2'b11: WB_wr, same file, address equal.
  - 2'b00: otherwise, or EX_rs_en[i] = 0, or the match is scalar register 0 with ZERO_REG = 1.
  - "Same file" means EX_rs_vec[i] equals the corresponding *_rd_vec.
- Scoreboard: cnt[file][reg], LAT_W bits each.
  - Issue = ID_valid && !ID_stall.
  - On issue with ID_wr and ID_lat > 0, cnt[ID_rd_vec][ID_rd] loads min(ID_lat, MAX_LAT).
  - Every nonzero counter decrements by 1 each cycle.
  - A load and a decrement never target the same entry, because WAW stalls prevent it.
- Unit busy counter mc_cnt, LAT_W bits.
  - Loads min(ID_lat, MAX_LAT) on issue with ID_lat > 0.
  - Decrements to 0 otherwise.
  - The unit is non-pipelined.
- ID_stall (combinational) = ID_valid AND any of the following:
  - RAW: an enabled ID source with a nonzero counter.
  - WAW: ID_wr with a nonzero counter at the ID destination.
  - Structural: ID_lat > 0 and mc_cnt != 0.
  - Scalar register 0 is exempt from RAW and WAW when ZERO_REG = 1.
- stall_cnt increments on each cycle with ID_stall = 1 and saturates at 32'hFFFF_FFFF.
- Reset mid-operation clears all pending entries immediately. Any in-flight multi-cycle result is then unguarded, and the pipeline is flushed by the same reset.

## Timing

- Reset values: all counters 0, mc_cnt 0, stall_cnt 0.
  - FwSel and ID_stall are combinational. With ID_valid = 0 and all EX_rs_en = 0, both are 0.
- FwSel has zero latency from the EX/MEM/WB inputs.
- Issue with latency L at edge t:
  - The counter reads L after edge t.
  - A dependent instruction in decode stalls for exactly L cycles.
  - It issues at edge t+L+1.
- A second multi-cycle issue is likewise held until mc_cnt = 0, at edge t+L+1 at the earliest.
- ID_lat = 0 never stalls by itself; single-cycle RAW dependencies are resolved by FwSel.
- ID_lat > MAX_LAT is clamped to MAX_LAT.

## Structure

- Package hazard_pkg holds:
  - fw_sel_e enum: FW_REG = 2'b00, FW_MEM_LOAD = 2'b01, FW_MEM_ALU = 2'b10, FW_WB = 2'b11.
  - rf_e enum: RF_SCALAR = 0, RF_VECTOR = 1.
  - Default parameter constants.
- Sub-module fwd_src_select computes the per-source priority select and is instantiated NUM_SRC times in a generate loop.
- The scoreboard, busy counter, stall logic and stall_cnt live in the top module.

## Test plan

- Forwarding priority and namespace: EX_rs = scalar 5; MEM_rd = scalar 5 with MEM_wr = 1, MEM_MemToReg = 0; WB_rd = scalar 5 with WB_wr = 1 -> FwSel = 2'b10. Change MEM_rd_vec to 1 -> 2'b11.
- Zero register: EX_rs = scalar 0, MEM_rd = scalar 0, MEM_wr = 1 -> 2'b00. The same case with vector register 0 -> 2'b10.
- Multi-cycle RAW: issue vector rd = 3 with ID_lat = 4, then decode reads vector 3 -> ID_stall high for exactly 4 cycles; issue follows on the 5th cycle; stall_cnt = 4.
- WAW and structural: after a lat-6 issue to vector 2, a lat-0 write to vector 2 stalls. A lat-2 write to vector 7 stalls until mc_cnt = 0. A lat-0 write to scalar 9 issues with no stall.
- Clamp and saturation: ID_lat = 15 with MAX_LAT = 8 -> 8 stall cycles. With stall_cnt forced to 32'hFFFF_FFFE, two stall cycles -> 32'hFFFF_FFFF, then it holds.
- Reset mid-operation: assert rst_n = 0 while a counter reads 3 -> all counters, mc_cnt and stall_cnt read 0 immediately. After release, a dependent decode issues with no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default parameters for the forwarding/hazard unit.
//   fw_sel_e : EX operand forwarding select encoding
//   rf_e     : register file namespace (scalar / vector)
package hazard_pkg;

  typedef enum logic [1:0] {
    FW_REG      = 2'b00,
    FW_MEM_LOAD = 2'b01,
    FW_MEM_ALU  = 2'b10,
    FW_WB       = 2'b11
  } fw_sel_e;

  typedef enum logic {
    RF_SCALAR = 1'b0,
    RF_VECTOR = 1'b1
  } rf_e;

  localparam int DEF_NUM_SRC  = 3;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_MAX_LAT  = 8;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand forwarding select for one EX source.
//   rs, rs_vec, rs_en       : EX source address, file, used flag
//   mem_rd, mem_rd_vec      : MEM destination address / file
//   mem_wr, mem_load        : MEM write enable / MEM is a load
//   wb_rd, wb_rd_vec, wb_wr : WB destination address / file / write enable
//   sel                     : forward select (MEM beats WB, load beats ALU)
module fwd_src_select
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_vec,
  input  logic              rs_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rd_vec,
  input  logic              mem_wr,
  input  logic              mem_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rd_vec,
  input  logic              wb_wr,
  output fw_sel_e           sel
);

  logic rs_zero;
  logic mem_hit;
  logic wb_hit;

  // Scalar r0 is hardwired; a match on it must read the register file.
  assign rs_zero = (ZERO_REG != 0) && (rs_vec == RF_SCALAR) && (rs == '0);

  assign mem_hit = rs_en && !rs_zero && mem_wr && (mem_rd_vec == rs_vec) && (mem_rd == rs);
  assign wb_hit  = rs_en && !rs_zero && wb_wr  && (wb_rd_vec  == rs_vec) && (wb_rd  == rs);

  always_comb begin
    sel = FW_REG;
    if (mem_hit) begin
      sel = mem_load ? FW_MEM_LOAD : FW_MEM_ALU;
    end else if (wb_hit) begin
      sel = FW_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit for the scalar/vector AES pipeline.
//   EX_*          : EX-stage sources, forwarded from MEM/WB via FwSel
//   MEM_*, WB_*   : downstream destinations and write enables
//   ID_*          : decode instruction, checked against the scoreboard
//   FwSel         : 2 bits per EX source
//   ID_stall      : hold IF/ID and bubble EX (RAW / WAW / structural)
//   stall_cnt     : saturating count of stalled cycles
// The scoreboard tracks pending multi-cycle writes per register and file;
// the busy counter models the single non-pipelined multi-cycle unit.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter  int NUM_SRC  = DEF_NUM_SRC,
  parameter  int REG_AW   = DEF_REG_AW,
  parameter  int MAX_LAT  = DEF_MAX_LAT,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] EX_rs,
  input  logic [NUM_SRC-1:0]        EX_rs_vec,
  input  logic [NUM_SRC-1:0]        EX_rs_en,
  input  logic [REG_AW-1:0]         MEM_rd,
  input  logic [REG_AW-1:0]         WB_rd,
  input  logic                      MEM_rd_vec,
  input  logic                      WB_rd_vec,
  input  logic                      MEM_wr,
  input  logic                      WB_wr,
  input  logic                      MEM_MemToReg,
  input  logic                      ID_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ID_rs,
  input  logic [NUM_SRC-1:0]        ID_rs_vec,
  input  logic [NUM_SRC-1:0]        ID_rs_en,
  input  logic [REG_AW-1:0]         ID_rd,
  input  logic                      ID_rd_vec,
  input  logic                      ID_wr,
  input  logic [LAT_W-1:0]          ID_lat,
  output logic [NUM_SRC*2-1:0]      FwSel,
  output logic                      ID_stall,
  output logic [31:0]               stall_cnt
);

  localparam int NUM_REGS = 2 ** REG_AW;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (int'(lat) > MAX_LAT) return LAT_W'(MAX_LAT);
    return lat;
  endfunction

  function automatic logic is_zero_reg(input logic vec, input logic [REG_AW-1:0] addr);
    return (ZERO_REG != 0) && (vec == RF_SCALAR) && (addr == '0);
  endfunction

  // EX forwarding selects
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fw_sel_e sel;

    fwd_src_select #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .rs         (EX_rs[i*REG_AW +: REG_AW]),
      .rs_vec     (EX_rs_vec[i]),
      .rs_en      (EX_rs_en[i]),
      .mem_rd     (MEM_rd),
      .mem_rd_vec (MEM_rd_vec),
      .mem_wr     (MEM_wr),
      .mem_load   (MEM_MemToReg),
      .wb_rd      (WB_rd),
      .wb_rd_vec  (WB_rd_vec),
      .wb_wr      (WB_wr),
      .sel        (sel)
    );

    assign FwSel[i*2 +: 2] = sel;
  end

  logic [LAT_W-1:0] cnt_q [2][NUM_REGS];
  logic [LAT_W-1:0] mc_cnt_q;
  logic [31:0]      stall_cnt_q;
  logic [LAT_W-1:0] lat_eff;
  logic             issue;
  logic             load_sb;
  logic             raw_hit;
  logic             waw_hit;
  logic             struct_hit;

  assign lat_eff = clamp_lat(ID_lat);
  assign issue   = ID_valid && !ID_stall;
  // r0 writes are never tracked since r0 reads are never stalled.
  assign load_sb = issue && ID_wr && (ID_lat != '0) && !is_zero_reg(ID_rd_vec, ID_rd);

  // Decode-stage hazard detection
  always_comb begin
    logic [REG_AW-1:0] rs_a;
    rs_a    = '0;
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_a = ID_rs[i*REG_AW +: REG_AW];
      if (ID_rs_en[i] && !is_zero_reg(ID_rs_vec[i], rs_a) &&
          (cnt_q[ID_rs_vec[i]][rs_a] != '0)) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit    = ID_wr && !is_zero_reg(ID_rd_vec, ID_rd) && (cnt_q[ID_rd_vec][ID_rd] != '0);
  assign struct_hit = (ID_lat != '0) && (mc_cnt_q != '0);
  assign ID_stall   = ID_valid && (raw_hit || waw_hit || struct_hit);

  // Scoreboard: load on multi-cycle issue, otherwise count down to zero.
  // WAW stalls guarantee a load never lands on a still-pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt_q[f][r] <= '0;
        end
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (load_sb && (ID_rd_vec == 1'(f)) && (ID_rd == REG_AW'(r))) begin
            cnt_q[f][r] <= lat_eff;
          end else if (cnt_q[f][r] != '0) begin
            cnt_q[f][r] <= cnt_q[f][r] - 1'b1;
          end
        end
      end
    end
  end

  // Busy counter of the non-pipelined multi-cycle unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_q <= '0;
    end else if (issue && (ID_lat != '0)) begin
      mc_cnt_q <= lat_eff;
    end else if (mc_cnt_q != '0) begin
      mc_cnt_q <= mc_cnt_q - 1'b1;
    end
  end

  // Stall-cycle performance counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (ID_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
